// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: modulus and operand width.
package ntt_pkg;
    parameter int DATA_WIDTH = 12;
    parameter int Q          = 3329;
endpackage

// File: rtl/mont_conv.sv
// Bit-serial Montgomery-domain converter (x*2^WIDTH or x*2^-WIDTH mod Q) using shift/add/subtract only.
// Optional macro MONT_CONV_B2B_EN: retire a result and accept the next operand on the same edge.
module mont_conv
    import ntt_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_dir,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int XW = DATA_WIDTH + 1;
    localparam logic [XW:0]           Q_EXT   = (XW + 1)'(Q);
    localparam logic [DATA_WIDTH-1:0] Q_DATA  = DATA_WIDTH'(Q);
    localparam logic [CW-1:0]         CNT_END = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [XW-1:0]           x_reg, x_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    dir_reg, dir_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    // Holds in_ready low until the first edge after reset release.
    logic                    ready_en_reg;

    logic                    accept;
    logic                    retire;
    logic [XW:0]             dbl_t;
    logic [XW:0]             dbl_val;
    logic [XW:0]             half_sum;
    logic [XW:0]             half_val;
    logic [XW-1:0]           iter_val;

    // One Montgomery step: modular doubling or halving depending on direction.
    always_comb begin
        dbl_t    = {x_reg, 1'b0};
        dbl_val  = (dbl_t >= Q_EXT) ? (dbl_t - Q_EXT) : dbl_t;
        half_sum = {1'b0, x_reg} + (x_reg[0] ? Q_EXT : '0);
        half_val = half_sum >> 1;
        iter_val = dir_reg ? half_val[XW-1:0] : dbl_val[XW-1:0];
    end

    always_comb begin
        in_ready = 1'b0;
        if (ready_en_reg) begin
            if (state_reg == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef MONT_CONV_B2B_EN
            else if (state_reg == DONE) begin
                in_ready = out_ready;
            end
`endif
        end
    end

    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        state_next    = state_reg;
        x_next        = x_reg;
        cnt_next      = cnt_reg;
        dir_next      = dir_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    x_next        = (in_data == Q_DATA) ? '0 : {1'b0, in_data};
                    dir_next      = in_dir;
                    cnt_next      = '0;
                    out_data_next = '0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                x_next   = iter_val;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CNT_END) begin
                    out_data_next = iter_val[DATA_WIDTH-1:0];
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (retire) begin
                    state_next = IDLE;
`ifdef MONT_CONV_B2B_EN
                    if (accept) begin
                        x_next        = (in_data == Q_DATA) ? '0 : {1'b0, in_data};
                        dir_next      = in_dir;
                        cnt_next      = '0;
                        out_data_next = '0;
                        state_next    = RUN;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            cnt_reg      <= '0;
            dir_reg      <= 1'b0;
            out_data_reg <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            cnt_reg      <= cnt_next;
            dir_reg      <= dir_next;
            out_data_reg <= out_data_next;
            ready_en_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mont_conv.sv
// Self-checking bench for mont_conv: directed steps with randomized operands against a modular-arithmetic model.
module tb_mont_conv;
    import ntt_pkg::*;

    localparam int W = DATA_WIDTH;
`ifdef MONT_CONV_B2B_EN
    localparam int SPACING = W + 1;
`else
    localparam int SPACING = W + 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_dir;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    int checks   = 0;
    int failures = 0;
    longint r_mod;
    longint r_inv;

    mont_conv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: x*2^W mod Q into the domain, x*(2^W)^-1 mod Q out of it; Q is treated as 0.
    function automatic longint model(input bit d, input longint v);
        longint x;
        x = (v == Q) ? 0 : v;
        return d ? (x * r_inv) % Q : (x * r_mod) % Q;
    endfunction

    // One full conversion with optional backpressure; scrambles inputs while busy.
    task automatic convert(input bit d, input int v, input int hold, output int res);
        int cycles;
        int held;
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_dir   = d;
        in_data  = DATA_WIDTH'(v);
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && cycles < 40) begin
            in_dir  = 1'($urandom);
            in_data = DATA_WIDTH'($urandom);
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (!out_valid) check("busy_in_ready", in_ready, 0);
        end
        check("latency", cycles, W);
        res = int'(out_data);
        check(d ? "result_out" : "result_in", res, model(d, v));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_data", out_data, res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("retired_valid", out_valid, 0);
        check("post_retire_ready", in_ready, 1);
    endtask

    initial begin
        int res;
        int back;
        int x;
        int last_cyc;
        int n_out;
        int idx;
        bit acc;
        bit ret;
        int ops[10];
        bit dirs[10];
        longint exp_q[$];

        r_mod = (longint'(1) << W) % Q;
        r_inv = 0;
        for (longint k = 1; k < Q; k++) begin
            if ((k * r_mod) % Q == 1) r_inv = k;
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_dir    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_edge_ready", in_ready, 1);

        // Directed values from the known Q=3329 points.
        convert(1'b0, 1, 0, res);
        check("into_1", res, 767);
        convert(1'b0, 3328, 0, res);
        check("into_3328", res, 2562);
        convert(1'b0, 0, 0, res);
        check("into_0", res, 0);
        convert(1'b0, Q, 0, res);
        check("into_q", res, 0);
        convert(1'b1, 767, 0, res);
        check("out_767", res, 1);
        convert(1'b1, 2562, 0, res);
        check("out_2562", res, 3328);
        convert(1'b1, Q, 0, res);
        check("out_q", res, 0);

        // Backpressure hold of five cycles.
        convert(1'b0, int'($urandom_range(0, Q - 1)), 5, res);

        // Reset in the middle of an iteration run.
        @(negedge clk);
        in_valid = 1'b1;
        in_dir   = 1'b0;
        in_data  = DATA_WIDTH'(1234);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_out_valid", out_valid, 0);
        check("midrun_out_data", out_data, 0);
        check("midrun_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_no_stale", out_valid, 0);
        convert(1'b0, 2000, 0, res);

        // Round trip into and back out of the domain.
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(0, Q - 1));
            convert(1'b0, x, 0, res);
            convert(1'b1, res, 0, back);
            check("round_trip", back, x);
        end

        // Streaming with both handshakes held high.
        for (int i = 0; i < 10; i++) begin
            ops[i]  = int'($urandom_range(0, Q));
            dirs[i] = 1'($urandom);
        end
        @(negedge clk);
        idx       = 0;
        n_out     = 0;
        last_cyc  = 0;
        in_valid  = 1'b1;
        in_dir    = dirs[0];
        in_data   = DATA_WIDTH'(ops[0]);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && n_out < 10; cyc++) begin
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                if (exp_q.size() > 0) check("stream_data", out_data, exp_q.pop_front());
                else check("stream_extra", 1, 0);
                if (n_out > 0) check("stream_spacing", cyc - last_cyc, SPACING);
                last_cyc = cyc;
                n_out++;
            end
            if (acc) begin
                exp_q.push_back(model(dirs[idx], ops[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx < 10) begin
                    in_dir  = dirs[idx];
                    in_data = DATA_WIDTH'(ops[idx]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("stream_count", n_out, 10);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
